// File: rtl/decode_sb_if.sv
// Decode-stage scoreboard bundle: issue request, writeback/squash retire ports
// and the hazard/pending status returned to decode.
interface decode_sb_if #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
);
    logic                issue_valid;
    logic [IDX_W-1:0]    issue_rs;
    logic [IDX_W-1:0]    issue_rt;
    logic                issue_rs_used;
    logic                issue_rt_used;
    logic                issue_wr_en;
    logic [IDX_W-1:0]    issue_rd;
    logic                wb_valid;
    logic [IDX_W-1:0]    wb_rd;
    logic                sq_valid;
    logic [IDX_W-1:0]    sq_rd;
    logic                stall;
    logic                issue_fire;
    logic [NUM_REGS-1:0] pending;
    logic                err;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
               issue_wr_en, issue_rd, wb_valid, wb_rd, sq_valid, sq_rd,
        input  stall, issue_fire, pending, err
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
               issue_wr_en, issue_rd, wb_valid, wb_rd, sq_valid, sq_rd,
        output stall, issue_fire, pending, err
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard: per-register outstanding-write counters that
// stall decode on RAW/dest-overflow hazards, with optional writeback bypass.
module decode_sb_cnt #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic [1:0]       dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             pend_o,
    output logic             unf_o,
    output logic             ovf_o
);
    localparam logic [CNT_W+1:0] MAXV = (CNT_W+2)'(MAX_PEND);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+1:0] sum, dec_w, net;

    // Increment and decrements are netted so a same-cycle issue+retire is a no-op.
    always_comb begin
        sum   = {2'b00, cnt_q} + (CNT_W+2)'(inc_i);
        dec_w = (CNT_W+2)'(dec_i);
        net   = sum - dec_w;
        cnt_d = cnt_q;
        unf_o = 1'b0;
        ovf_o = 1'b0;
        if (dec_w > sum) begin
            cnt_d = '0;
            unf_o = 1'b1;
        end else if (net > MAXV) begin
            cnt_d = MAXV[CNT_W-1:0];
            ovf_o = 1'b1;
        end else begin
            cnt_d = net[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign pend_o = |cnt_q;
endmodule

module decode_scoreboard #(
    parameter int NUM_REGS  = 8,
    parameter int IDX_W     = 3,
    parameter int MAX_PEND  = 3,
    parameter int BYPASS_WB = 1,
    parameter int CNT_W     = $clog2(MAX_PEND + 1)
) (
    input logic        clk,
    input logic        rst,
    decode_sb_if.slave sb
);
    localparam int               DEPTH   = 2 ** IDX_W;
    localparam logic [IDX_W:0]   NREG    = (IDX_W+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             BYP     = (BYPASS_WB != 0);

    function automatic logic oor(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} >= NREG;
    endfunction

    // Padded to the full index space so any index can be looked up safely.
    logic [DEPTH-1:0][CNT_W-1:0] cnt_full;
    logic [NUM_REGS-1:0]         pend, unf, ovf;
    logic [CNT_W-1:0]            rs_cnt, rt_cnt, rd_cnt;
    logic                        rs_byp, rt_byp, rs_haz, rt_haz, dest_haz;
    logic                        stall, fire, oor_evt;
    logic                        err_q, err_d;

    always_comb begin
        rs_cnt   = cnt_full[sb.issue_rs];
        rt_cnt   = cnt_full[sb.issue_rt];
        rd_cnt   = cnt_full[sb.issue_rd];
        // Last outstanding write retiring this cycle forwards its value.
        rs_byp   = BYP && sb.wb_valid && (sb.wb_rd == sb.issue_rs) && (rs_cnt == CNT_ONE);
        rt_byp   = BYP && sb.wb_valid && (sb.wb_rd == sb.issue_rt) && (rt_cnt == CNT_ONE);
        rs_haz   = sb.issue_rs_used && (oor(sb.issue_rs) || ((rs_cnt != '0) && !rs_byp));
        rt_haz   = sb.issue_rt_used && (oor(sb.issue_rt) || ((rt_cnt != '0) && !rt_byp));
        dest_haz = sb.issue_wr_en && !oor(sb.issue_rd) && (rd_cnt == CNT_MAX);
        stall    = sb.issue_valid && (rs_haz || rt_haz || dest_haz);
        fire     = sb.issue_valid && !stall;
        oor_evt  = (sb.issue_valid && ((sb.issue_rs_used && oor(sb.issue_rs)) ||
                                       (sb.issue_rt_used && oor(sb.issue_rt)) ||
                                       (sb.issue_wr_en   && oor(sb.issue_rd)))) ||
                   (sb.wb_valid && oor(sb.wb_rd)) ||
                   (sb.sq_valid && oor(sb.sq_rd));
        err_d    = err_q || (|unf) || (|ovf) || oor_evt;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if (gi < NUM_REGS) begin : g_live
            logic       inc, wb_hit, sq_hit;
            logic [1:0] dec;
            assign inc    = fire && sb.issue_wr_en && (sb.issue_rd == IDX_W'(gi));
            assign wb_hit = sb.wb_valid && (sb.wb_rd == IDX_W'(gi));
            assign sq_hit = sb.sq_valid && (sb.sq_rd == IDX_W'(gi));
            assign dec    = {1'b0, wb_hit} + {1'b0, sq_hit};

            decode_sb_cnt #(
                .MAX_PEND(MAX_PEND),
                .CNT_W   (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc_i (inc),
                .dec_i (dec),
                .cnt_o (cnt_full[gi]),
                .pend_o(pend[gi]),
                .unf_o (unf[gi]),
                .ovf_o (ovf[gi])
            );
        end else begin : g_pad
            assign cnt_full[gi] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign sb.stall      = stall;
    assign sb.issue_fire = fire;
    assign sb.pending    = pend;
    assign sb.err        = err_q;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed vector table, async-reset sequence and
// randomized traffic on two configurations against a counter-array model.
module tb_decode_scoreboard;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_sb_if #(.NUM_REGS(8), .IDX_W(3)) if0 ();
    decode_sb_if #(.NUM_REGS(6), .IDX_W(3)) if1 ();

    decode_scoreboard #(.NUM_REGS(8), .IDX_W(3), .MAX_PEND(MAXP), .BYPASS_WB(1))
        dut0 (.clk(clk), .rst(rst), .sb(if0.slave));
    decode_scoreboard #(.NUM_REGS(6), .IDX_W(3), .MAX_PEND(MAXP), .BYPASS_WB(0))
        dut1 (.clk(clk), .rst(rst), .sb(if1.slave));

    typedef struct {
        bit iv; int rs; int rt; bit rsu; bit rtu; bit we; int rd;
        bit wv; int wrd; bit sv; int srd;
    } stim_t;

    typedef struct {
        stim_t      s;
        bit         stall0;
        bit         stall1;
        logic [7:0] pend0;
        bit         err0;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int mc[2][8];
    bit me[2];
    int NR[2] = '{8, 6};
    bit BY[2] = '{1'b1, 1'b0};

    vec_t tbl[$];

    function automatic stim_t mk(bit iv, int rs, int rt, bit rsu, bit rtu, bit we, int rd,
                                 bit wv, int wrd, bit sv, int srd);
        stim_t s;
        s.iv = iv; s.rs = rs; s.rt = rt; s.rsu = rsu; s.rtu = rtu; s.we = we; s.rd = rd;
        s.wv = wv; s.wrd = wrd; s.sv = sv; s.srd = srd;
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain per-register counts of outstanding writes.
    function automatic bit m_src(int k, int r, bit used, stim_t s);
        if (!used) return 1'b0;
        if (r >= NR[k]) return 1'b1;
        if (mc[k][r] == 0) return 1'b0;
        if (BY[k] && mc[k][r] == 1 && s.wv && s.wrd == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall(int k, stim_t s);
        bit dh;
        if (!s.iv) return 1'b0;
        dh = s.we && s.rd < NR[k] && mc[k][s.rd] == MAXP;
        return m_src(k, s.rs, s.rsu, s) || m_src(k, s.rt, s.rtu, s) || dh;
    endfunction

    function automatic logic [7:0] m_pend(int k);
        logic [7:0] p = '0;
        for (int i = 0; i < NR[k]; i++) p[i] = (mc[k][i] != 0);
        return p;
    endfunction

    task automatic m_step(int k, stim_t s);
        bit fire;
        int n;
        fire = s.iv && !m_stall(k, s);
        if (s.iv && ((s.rsu && s.rs >= NR[k]) || (s.rtu && s.rt >= NR[k]) ||
                     (s.we && s.rd >= NR[k]))) me[k] = 1'b1;
        if (s.wv && s.wrd >= NR[k]) me[k] = 1'b1;
        if (s.sv && s.srd >= NR[k]) me[k] = 1'b1;
        for (int i = 0; i < NR[k]; i++) begin
            n = mc[k][i] + ((fire && s.we && s.rd == i) ? 1 : 0)
                         - ((s.wv && s.wrd == i) ? 1 : 0)
                         - ((s.sv && s.srd == i) ? 1 : 0);
            if (n < 0) begin n = 0; me[k] = 1'b1; end
            mc[k][i] = n;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            me[k] = 1'b0;
            for (int i = 0; i < 8; i++) mc[k][i] = 0;
        end
    endtask

    task automatic apply(stim_t a, stim_t b);
        if0.issue_valid = a.iv;  if0.issue_rs = 3'(a.rs);  if0.issue_rt = 3'(a.rt);
        if0.issue_rs_used = a.rsu; if0.issue_rt_used = a.rtu;
        if0.issue_wr_en = a.we;  if0.issue_rd = 3'(a.rd);
        if0.wb_valid = a.wv;     if0.wb_rd = 3'(a.wrd);
        if0.sq_valid = a.sv;     if0.sq_rd = 3'(a.srd);
        if1.issue_valid = b.iv;  if1.issue_rs = 3'(b.rs);  if1.issue_rt = 3'(b.rt);
        if1.issue_rs_used = b.rsu; if1.issue_rt_used = b.rtu;
        if1.issue_wr_en = b.we;  if1.issue_rd = 3'(b.rd);
        if1.wb_valid = b.wv;     if1.wb_rd = 3'(b.wrd);
        if1.sq_valid = b.sv;     if1.sq_rd = 3'(b.srd);
    endtask

    // One clock: drive at negedge, check combinational outputs, then state after the edge.
    task automatic cycle(input stim_t a, input stim_t b,
                         output bit st0, output bit st1, output logic [7:0] p0, output bit e0);
        bit x0, x1;
        apply(a, b);
        #2;
        x0 = m_stall(0, a);
        x1 = m_stall(1, b);
        chk("stall0", int'(if0.stall), int'(x0));
        chk("fire0",  int'(if0.issue_fire), int'(a.iv && !x0));
        chk("stall1", int'(if1.stall), int'(x1));
        chk("fire1",  int'(if1.issue_fire), int'(b.iv && !x1));
        st0 = if0.stall;
        st1 = if1.stall;
        m_step(0, a);
        m_step(1, b);
        @(posedge clk);
        #1;
        chk("pend0", int'(if0.pending), int'(m_pend(0)));
        chk("err0",  int'(if0.err), int'(me[0]));
        chk("pend1", int'({2'b00, if1.pending}), int'(m_pend(1)));
        chk("err1",  int'(if1.err), int'(me[1]));
        p0 = if0.pending;
        e0 = if0.err;
        @(negedge clk);
    endtask

    task automatic do_reset();
        stim_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0);
        @(negedge clk);
        rst = 1'b1;
        apply(idle, idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    function automatic int rnd_idx(int k);
        return ($urandom % 16 == 0) ? int'($urandom % 8) : int'($urandom % NR[k]);
    endfunction

    function automatic stim_t rnd_stim(int k);
        stim_t s;
        s.iv  = ($urandom % 4) != 0;
        s.rs  = rnd_idx(k);  s.rt = rnd_idx(k);
        s.rsu = $urandom % 2; s.rtu = $urandom % 2;
        s.we  = ($urandom % 3) != 0;
        s.rd  = rnd_idx(k);
        s.wrd = rnd_idx(k);
        s.wv  = (s.wrd < NR[k] && mc[k][s.wrd] > 0) ? bit'($urandom % 2) : ($urandom % 40 == 0);
        s.srd = rnd_idx(k);
        s.sv  = (s.srd < NR[k] && mc[k][s.srd] > 0) ? ($urandom % 5 == 0) : ($urandom % 60 == 0);
        return s;
    endfunction

    initial begin
        stim_t      s, idle, probe, a, b;
        bit         st0, st1, e0;
        logic [7:0] p0;

        idle = mk(0,0,0,0,0,0,0,0,0,0,0);

        // iv rs rt rsu rtu we rd wv wrd sv srd ; stall0 stall1 pend0 err0
        tbl.push_back('{mk(1,0,0,0,0,1,3,0,0,0,0), 0, 0, 8'h08, 0});
        tbl.push_back('{mk(1,3,0,1,0,0,0,0,0,0,0), 1, 1, 8'h08, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,3,0,0), 0, 0, 8'h00, 0});
        tbl.push_back('{mk(1,3,0,1,0,0,0,0,0,0,0), 0, 0, 8'h00, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,5,0,0,0,0), 0, 0, 8'h20, 0});
        tbl.push_back('{mk(1,5,0,1,0,0,0,1,5,0,0), 0, 1, 8'h00, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,2,0,0,0,0), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,2,0,0,0,0), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,2,0,0,0,0), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,2,0,0,0,0), 1, 1, 8'h04, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,2,0,0), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,2,0,0,0,0), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,2,1,2), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,2,0,0), 0, 0, 8'h00, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,1,0,0,0,0), 0, 0, 8'h02, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,1,1,1,0,0), 0, 0, 8'h02, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,1,0,0), 0, 0, 8'h00, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,4,0,0,0,0), 0, 0, 8'h10, 0});
        tbl.push_back('{mk(1,0,0,0,0,1,4,0,0,0,0), 0, 0, 8'h10, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,4,1,4), 0, 0, 8'h00, 0});
        tbl.push_back('{mk(1,2,0,1,0,1,2,0,0,0,0), 0, 0, 8'h04, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,2,0,0), 0, 0, 8'h00, 0});
        tbl.push_back('{mk(0,0,0,0,0,0,0,1,6,0,0), 0, 0, 8'h00, 1});
        tbl.push_back('{mk(0,0,0,0,0,0,0,0,0,0,0), 0, 0, 8'h00, 1});

        // Reset state, with a source-reading issue presented while held in reset.
        rst = 1'b1;
        apply(mk(1,3,4,1,1,1,3,0,0,0,0), mk(1,3,4,1,1,1,3,0,0,0,0));
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pend0",  int'(if0.pending), 0);
        chk("rst_err0",   int'(if0.err), 0);
        chk("rst_stall0", int'(if0.stall), 0);
        chk("rst_fire0",  int'(if0.issue_fire), 1);
        chk("rst_pend1",  int'(if1.pending), 0);
        apply(idle, idle);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].s, tbl[i].s, st0, st1, p0, e0);
            chk($sformatf("tbl%0d_stall0", i), int'(st0), int'(tbl[i].stall0));
            chk($sformatf("tbl%0d_stall1", i), int'(st1), int'(tbl[i].stall1));
            chk($sformatf("tbl%0d_pend0", i),  int'(p0),  int'(tbl[i].pend0));
            chk($sformatf("tbl%0d_err0", i),   int'(e0),  int'(tbl[i].err0));
        end

        // Out-of-range source on the 6-register config stalls and flags err.
        do_reset();
        s = mk(1,7,0,1,0,0,0,0,0,0,0);
        cycle(idle, s, st0, st1, p0, e0);
        chk("oor_src_stall1", int'(st1), 1);
        chk("oor_src_err1", int'(if1.err), 1);

        // Async reset mid-cycle with live counts.
        do_reset();
        s = mk(1,0,0,0,0,1,0,0,0,0,0);
        cycle(s, s, st0, st1, p0, e0);
        s = mk(0,0,0,0,0,0,0,1,6,0,0);
        cycle(s, idle, st0, st1, p0, e0);
        probe = mk(1,0,0,1,0,0,0,0,0,0,0);
        apply(probe, probe);
        #2;
        chk("pre_rst_stall0", int'(if0.stall), 1);
        chk("pre_rst_err0",   int'(if0.err), 1);
        rst = 1'b1;
        #1;
        chk("arst_pend0",  int'(if0.pending), 0);
        chk("arst_err0",   int'(if0.err), 0);
        chk("arst_stall0", int'(if0.stall), 0);
        chk("arst_fire0",  int'(if0.issue_fire), 1);
        chk("arst_pend1",  int'(if1.pending), 0);
        @(negedge clk);
        apply(idle, idle);
        rst = 1'b0;
        m_reset();

        // Randomized traffic, reset between bursts so sticky err does not mask later checks.
        for (int chunk = 0; chunk < 8; chunk++) begin
            do_reset();
            for (int n = 0; n < 250; n++) begin
                a = rnd_stim(0);
                b = rnd_stim(1);
                cycle(a, b, st0, st1, p0, e0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
